// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - video-priority arbiter sharing one single-port synchronous RAM with the CPU
// Optional CPU starvation guard with a one-entry pending video fetch: RAM_ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_valid,
  output logic                  ram_clken,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;

  tag_t                  grant;
  tag_t                  tag1;
  tag_t                  tag2;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  cpu_busy;
  logic                  cpu_ready;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_starve_limit_range
    $error("ram_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  assign cpu_ready = cpu_req && !cpu_busy;

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic [3:0]            starve_cnt;
  logic                  pend_full;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  force_cpu;

  // The guard never fires with pending full, so a displaced fetch always has room.
  assign force_cpu = cpu_ready && (starve_cnt >= 4'(STARVE_LIMIT)) && !pend_full;

  always_comb begin
    grant      = TAG_NONE;
    grant_addr = cpu_addr;
    if (force_cpu) begin
      grant = TAG_CPU;
    end else if (pend_full) begin
      grant      = TAG_VID;
      grant_addr = pend_addr;
    end else if (vid_req) begin
      grant      = TAG_VID;
      grant_addr = vid_addr;
    end else if (cpu_ready) begin
      grant = TAG_CPU;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      pend_full  <= 1'b0;
      pend_addr  <= '0;
    end else begin
      if (grant == TAG_CPU) begin
        starve_cnt <= '0;
      end else if (cpu_ready && (starve_cnt < 4'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      // A new fetch parks in pending while pending (or the forced CPU slot) owns the port.
      if (force_cpu || pend_full) begin
        pend_full <= vid_req;
        if (vid_req) begin
          pend_addr <= vid_addr;
        end
      end
    end
  end
`else
  always_comb begin
    grant      = TAG_NONE;
    grant_addr = cpu_addr;
    if (vid_req) begin
      grant      = TAG_VID;
      grant_addr = vid_addr;
    end else if (cpu_ready) begin
      grant = TAG_CPU;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_clken   <= 1'b0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      tag1        <= TAG_NONE;
      tag2        <= TAG_NONE;
      cpu_busy    <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_valid   <= 1'b0;
      vid_rdata   <= '0;
    end else begin
      ram_clken <= (grant != TAG_NONE);
      ram_wren  <= (grant == TAG_CPU) && cpu_we;
      if (grant != TAG_NONE) begin
        ram_address <= grant_addr;
      end
      if (grant == TAG_CPU) begin
        ram_data <= cpu_wdata;
      end
      tag1      <= grant;
      tag2      <= tag1;
      // Stage-2 tag lines up with the RAM's registered q.
      cpu_ack   <= (tag2 == TAG_CPU);
      vid_valid <= (tag2 == TAG_VID);
      if (tag2 == TAG_CPU) begin
        cpu_rdata <= ram_q;
      end
      if (tag2 == TAG_VID) begin
        vid_rdata <= ram_q;
      end
      if (grant == TAG_CPU) begin
        cpu_busy <= 1'b1;
      end else if (tag2 == TAG_CPU) begin
        cpu_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          ram_clken, ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .ram_clken(ram_clken), .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Read-before-write single-port RAM with registered q.
  always @(posedge clock) begin
    if (ram_clken) begin
      ram_q <= mem[ram_address];
      if (ram_wren) mem[ram_address] <= ram_data;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_total = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } vexp_t;
  vexp_t vq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic vid_push(input logic [AW-1:0] a, input logic [7:0] d, input int lat);
    vid_req  = 1'b1;
    vid_addr = a;
    vq.push_back('{d, cyc + 1 + lat});
  endtask

  always @(posedge clock) begin
    cyc++;
    #1;
    if (cpu_ack) ack_total++;
    if (vid_valid) begin
      if (vq.size() == 0) begin
        check("vid_spurious", 1, 0);
      end else begin
        vexp_t e;
        e = vq.pop_front();
        check("vid_data", vid_rdata, e.data);
        check("vid_cycle", cyc, e.due);
      end
    end
  end

  task automatic cpu_op(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick();
    n = 1;
    check({tag, "_grant"}, {ram_clken, ram_wren, ram_address}, {1'b1, we, a});
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    check({tag, "_lat"}, n, 3);
    check({tag, "_rdata"}, cpu_rdata, exp_rd);
    tick();
    check({tag, "_ack_pulse"}, cpu_ack, 0);
  endtask

  initial begin
    int ae;
    int n;
    int a0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    for (int i = 0; i < 4; i++) mem[i] <= 8'h10 + 8'(i);

    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_ram", {ram_clken, ram_wren, ram_address, ram_data}, 0);
    check("rst_cpu", {cpu_ack, cpu_rdata}, 0);
    check("rst_vid", {vid_valid, vid_rdata}, 0);
    reset_n = 1'b1;
    tick();

    cpu_op("wr1", 1'b1, 11'h123, 8'h5A, 8'h00);
    cpu_op("rd1", 1'b0, 11'h123, 8'h00, 8'h5A);
    cpu_op("wr2", 1'b1, 11'h123, 8'h77, 8'h5A);
    cpu_op("rd2", 1'b0, 11'h123, 8'h00, 8'h77);

    for (int i = 0; i < 4; i++) begin
      vid_push(11'(i), 8'h10 + 8'(i), 2);
      tick();
    end
    vid_req = 1'b0;
    repeat (4) tick();
    check("vid_burst_drained", vq.size(), 0);

    // Same-edge contention: video first, CPU on the following edge.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
    vid_push(11'h002, 8'h12, 2);
    tick();
    check("cont_vid_first", {ram_clken, ram_wren, ram_address}, {1'b1, 1'b0, 11'h002});
    vid_req = 1'b0;
    tick();
    check("cont_cpu_next", {ram_clken, ram_wren, ram_address}, {1'b1, 1'b0, 11'h123});
    tick();
    check("cont_ack_early", cpu_ack, 0);
    tick();
    check("cont_ack", cpu_ack, 1);
    check("cont_rdata", cpu_rdata, 8'h77);
    cpu_req = 1'b0;
    repeat (2) tick();

    // Continuous video with a held CPU read of 0x003.
    ae = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h003;
    for (int j = 0; j < 14; j++) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
      vid_push(11'(j % 4), 8'h10 + 8'(j % 4), (j < 8) ? 2 : 3);
`else
      vid_push(11'(j % 4), 8'h10 + 8'(j % 4), 2);
`endif
      tick();
      if (cpu_ack && ae == 0) begin
        ae = j + 1;
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    n = 14;
    while (ae == 0 && n < 40) begin
      tick();
      n++;
      if (cpu_ack) begin
        ae = n;
        cpu_req = 1'b0;
      end
    end
`ifdef RAM_ARB_STARVE_GUARD_EN
    check("starve_ack_edge", ae, 11);
`else
    check("starve_ack_edge", ae, 17);
`endif
    check("starve_rdata", cpu_rdata, 8'h13);
    tick();
    vid_push(11'h001, 8'h11, 2);
    tick();
    vid_req = 1'b0;
    repeat (4) tick();
    check("starve_vid_drained", vq.size(), 0);

    // Reset one edge after a CPU grant discards the access.
    a0 = ack_total;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
    tick();
    check("rstmid_grant", {ram_clken, ram_address}, {1'b1, 11'h123});
    reset_n = 1'b0;
    tick();
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("rstmid_no_ack", ack_total - a0, 0);
    check("rstmid_ram", {ram_clken, ram_wren, ram_address, ram_data}, 0);
    check("rstmid_cpu", {cpu_ack, cpu_rdata}, 0);
    check("rstmid_vid", {vid_valid, vid_rdata}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
